// File: rtl/settings_bus_arbiter.sv
// Round-robin arbiter sharing one settings bus among several AXI-stream command sources.
// Multi-beat (tlast-delimited) sequences stay atomic; an optional idle gap follows each strobe.
//   state   | meaning
//   ST_ARB  | no lock held, round-robin search every cycle
//   ST_LOCK | holding the last granted port until its tlast beat
//   ST_GAP  | forced idle cycles after a strobe, no tready
module settings_bus_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int AWIDTH    = 8,
  parameter int GAP       = 0
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic [NUM_PORTS*(AWIDTH+32)-1:0]         i_tdata,
  input  logic [NUM_PORTS-1:0]                     i_tlast,
  input  logic [NUM_PORTS-1:0]                     i_tvalid,
  output logic [NUM_PORTS-1:0]                     i_tready,
  output logic                                     set_stb,
  output logic [AWIDTH-1:0]                        set_addr,
  output logic [31:0]                              set_data,
  output logic [(NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1)-1:0] set_src,
  output logic                                     busy
);

  localparam int SW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int BW = AWIDTH + 32;

  typedef enum logic [1:0] {ST_ARB, ST_LOCK, ST_GAP} state_t;

  state_t          state;
  logic [SW-1:0]   last;
  logic            locked;
  logic [7:0]      gap_cnt;

  logic            grant_vld;
  logic [SW-1:0]   grant;
  logic [SW:0]     sum;
  logic [SW-1:0]   cand;
  logic [BW-1:0]   slice [NUM_PORTS];
  logic [BW-1:0]   beat;
  logic            beat_last;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_slice
    assign slice[k] = i_tdata[k*BW +: BW];
  end

  // Grant search starts just after the last accepted port and wraps once.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    sum       = '0;
    cand      = '0;
    if (state == ST_ARB) begin
      for (int i = 1; i <= NUM_PORTS; i++) begin
        sum = {1'b0, last} + (SW+1)'(i);
        if (sum >= (SW+1)'(NUM_PORTS)) sum = sum - (SW+1)'(NUM_PORTS);
        cand = sum[SW-1:0];
        if (!grant_vld && i_tvalid[cand]) begin
          grant_vld = 1'b1;
          grant     = cand;
        end
      end
    end else if (state == ST_LOCK && i_tvalid[last]) begin
      grant_vld = 1'b1;
      grant     = last;
    end
    i_tready = '0;
    if (grant_vld) i_tready[grant] = 1'b1;
    beat      = slice[grant];
    beat_last = i_tlast[grant];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_ARB;
      last     <= SW'(NUM_PORTS - 1);
      locked   <= 1'b0;
      gap_cnt  <= 8'd0;
      set_stb  <= 1'b0;
      set_addr <= '0;
      set_data <= '0;
      set_src  <= '0;
      busy     <= 1'b0;
    end else begin
      set_stb <= grant_vld;
      if (grant_vld) begin
        set_addr <= beat[AWIDTH+31:32];
        set_data <= beat[31:0];
        set_src  <= grant;
        last     <= grant;
        locked   <= !beat_last;
      end
      case (state)
        ST_ARB, ST_LOCK: begin
          if (grant_vld) begin
            if (GAP > 0) begin
              state   <= ST_GAP;
              gap_cnt <= 8'(GAP);
              busy    <= 1'b1;
            end else if (beat_last) begin
              state <= ST_ARB;
              busy  <= 1'b0;
            end else begin
              state <= ST_LOCK;
              busy  <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt - 8'd1;
          // Last gap cycle: resume the held sequence, or reopen arbitration.
          if (gap_cnt == 8'd1) begin
            state <= locked ? ST_LOCK : ST_ARB;
            busy  <= locked;
          end
        end
        default: begin
          state <= ST_ARB;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_settings_bus_arbiter.sv
// Bench for settings_bus_arbiter: directed scenarios on GAP=0/3/2 instances plus
// randomized traffic checked against a rule-level reference model.
module tb_settings_bus_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int BW = AW + 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n;
  logic [N*BW-1:0] tdata;
  logic [N-1:0]    tlast;
  logic [N-1:0]    tvalid;

  logic [N-1:0]  rdy  [3];
  logic          stb  [3];
  logic [AW-1:0] addr [3];
  logic [31:0]   data [3];
  logic [1:0]    src  [3];
  logic          bsy  [3];

  settings_bus_arbiter #(.NUM_PORTS(N), .AWIDTH(AW), .GAP(0)) dut_g0 (
    .clk(clk), .reset_n(reset_n), .i_tdata(tdata), .i_tlast(tlast), .i_tvalid(tvalid),
    .i_tready(rdy[0]), .set_stb(stb[0]), .set_addr(addr[0]), .set_data(data[0]),
    .set_src(src[0]), .busy(bsy[0]));
  settings_bus_arbiter #(.NUM_PORTS(N), .AWIDTH(AW), .GAP(3)) dut_g3 (
    .clk(clk), .reset_n(reset_n), .i_tdata(tdata), .i_tlast(tlast), .i_tvalid(tvalid),
    .i_tready(rdy[1]), .set_stb(stb[1]), .set_addr(addr[1]), .set_data(data[1]),
    .set_src(src[1]), .busy(bsy[1]));
  settings_bus_arbiter #(.NUM_PORTS(N), .AWIDTH(AW), .GAP(2)) dut_g2 (
    .clk(clk), .reset_n(reset_n), .i_tdata(tdata), .i_tlast(tlast), .i_tvalid(tvalid),
    .i_tready(rdy[2]), .set_stb(stb[2]), .set_addr(addr[2]), .set_data(data[2]),
    .set_src(src[2]), .busy(bsy[2]));

  // Outputs of the instance currently under test.
  logic [1:0]    sel;
  logic [N-1:0]  t_ready;
  logic          t_stb;
  logic [AW-1:0] t_addr;
  logic [31:0]   t_data;
  logic [1:0]    t_src;
  logic          t_busy;
  always_comb begin
    t_ready = rdy[sel];
    t_stb   = stb[sel];
    t_addr  = addr[sel];
    t_data  = data[sel];
    t_src   = src[sel];
    t_busy  = bsy[sel];
  end

  int checks = 0;
  int errors = 0;

  task automatic set_port(input int k, input logic v, input logic l,
                          input logic [AW-1:0] a, input logic [31:0] d);
    tvalid[k] = v;
    tlast[k]  = l;
    tdata[k*BW +: BW] = {a, d};
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tvalid  = '0;
    tlast   = '0;
    tdata   = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    sel = 2'd0;
    reset_n = 1'b0;
    tvalid = '0; tlast = '0; tdata = '0;
    #2;
    checks++; if (t_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b want 0", t_stb); end
    checks++; if (t_addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", t_addr); end
    checks++; if (t_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", t_data); end
    checks++; if (t_src !== 2'd0) begin errors++; $display("FAIL reset_src: got %0d want 0", t_src); end
    checks++; if (t_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", t_busy); end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({t_ready, t_stb, t_busy} !== 6'b0) begin
      errors++; $display("FAIL idle_after_reset: got ready=%b stb=%b busy=%b want all 0", t_ready, t_stb, t_busy);
    end
  endtask

  task automatic test_single_beat();
    sel = 2'd0;
    do_reset();
    set_port(2, 1'b1, 1'b1, 8'h15, 32'hDEADBEEF);
    #1;
    checks++; if (t_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", t_ready); end
    checks++; if (t_stb !== 1'b0) begin errors++; $display("FAIL single_prestb: got %b want 0", t_stb); end
    @(posedge clk); #1;
    set_port(2, 1'b0, 1'b0, 8'h00, 32'h0);
    checks++;
    if ({t_stb, t_addr, t_data, t_src} !== {1'b1, 8'h15, 32'hDEADBEEF, 2'd2}) begin
      errors++; $display("FAIL single_strobe: got stb=%b addr=%h data=%h src=%0d want 1/15/deadbeef/2", t_stb, t_addr, t_data, t_src);
    end
    @(posedge clk); #1;
    checks++;
    if ({t_stb, t_addr, t_data} !== {1'b0, 8'h15, 32'hDEADBEEF}) begin
      errors++; $display("FAIL single_hold: got stb=%b addr=%h data=%h want 0/15/deadbeef", t_stb, t_addr, t_data);
    end
  endtask

  task automatic test_rotation();
    sel = 2'd0;
    do_reset();
    for (int k = 0; k < N; k++) set_port(k, 1'b1, 1'b1, 8'(8'h40 + k), 32'(k) * 32'h1111);
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (t_ready !== (4'b0001 << (i % 4))) begin
        errors++; $display("FAIL rot_ready[%0d]: got %b want %b", i, t_ready, 4'b0001 << (i % 4));
      end
      @(posedge clk); #1;
      checks++;
      if ({t_stb, t_src, t_addr, t_data} !== {1'b1, 2'(i % 4), 8'(8'h40 + i % 4), 32'(i % 4) * 32'h1111}) begin
        errors++; $display("FAIL rot_strobe[%0d]: got stb=%b src=%0d addr=%h want 1/%0d/%h", i, t_stb, t_src, t_addr, i % 4, 8'h40 + i % 4);
      end
    end
    tvalid = '0;
  endtask

  task automatic test_lock();
    sel = 2'd0;
    do_reset();
    set_port(1, 1'b1, 1'b0, 8'h11, 32'hB1);
    #1;
    checks++; if (t_ready !== 4'b0010) begin errors++; $display("FAIL lock_first_ready: got %b want 0010", t_ready); end
    for (int b = 1; b < 3; b++) begin
      @(posedge clk); #1;
      checks++;
      if ({t_stb, t_src, t_busy} !== {1'b1, 2'd1, 1'b1}) begin
        errors++; $display("FAIL lock_beat[%0d]: got stb=%b src=%0d busy=%b want 1/1/1", b, t_stb, t_src, t_busy);
      end
      set_port(0, 1'b1, 1'b1, 8'h01, 32'hA0);
      set_port(3, 1'b1, 1'b1, 8'h03, 32'hA3);
      set_port(1, 1'b1, (b == 2), 8'(8'h11 + b), 32'hB1 + 32'(b));
      #1;
      checks++; if (t_ready !== 4'b0010) begin errors++; $display("FAIL lock_stall[%0d]: got %b want 0010", b, t_ready); end
    end
    @(posedge clk); #1;
    checks++;
    if ({t_stb, t_src, t_addr, t_busy} !== {1'b1, 2'd1, 8'h13, 1'b0}) begin
      errors++; $display("FAIL lock_release: got stb=%b src=%0d addr=%h busy=%b want 1/1/13/0", t_stb, t_src, t_addr, t_busy);
    end
    set_port(1, 1'b0, 1'b0, 8'h00, 32'h0);
    #1;
    checks++; if (t_ready !== 4'b1000) begin errors++; $display("FAIL lock_next_ready: got %b want 1000", t_ready); end
    @(posedge clk); #1;
    checks++; if ({t_stb, t_src} !== {1'b1, 2'd3}) begin errors++; $display("FAIL lock_next_src: got stb=%b src=%0d want 1/3", t_stb, t_src); end
    set_port(3, 1'b0, 1'b0, 8'h00, 32'h0);
    @(posedge clk); #1;
    checks++; if ({t_stb, t_src, t_addr} !== {1'b1, 2'd0, 8'h01}) begin errors++; $display("FAIL lock_after_src: got stb=%b src=%0d addr=%h want 1/0/01", t_stb, t_src, t_addr); end
    tvalid = '0;
  endtask

  task automatic test_gap();
    logic e_stb, e_busy;
    logic [N-1:0] e_rdy;
    sel = 2'd1;
    do_reset();
    set_port(0, 1'b1, 1'b1, 8'h10, 32'h1000);
    #1;
    checks++; if (t_ready !== 4'b0001) begin errors++; $display("FAIL gap_first_ready: got %b want 0001", t_ready); end
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      e_stb  = (k % 4 == 0);
      e_busy = (k % 4 != 3);
      e_rdy  = (k % 4 == 3) ? 4'b0001 : 4'b0000;
      checks++;
      if ({t_stb, t_busy, t_ready} !== {e_stb, e_busy, e_rdy}) begin
        errors++; $display("FAIL gap_cycle[%0d]: got stb=%b busy=%b ready=%b want %b/%b/%b", k, t_stb, t_busy, t_ready, e_stb, e_busy, e_rdy);
      end
      @(posedge clk); #1;
    end
    tvalid = '0;
  endtask

  task automatic test_reset_mid();
    sel = 2'd2;
    do_reset();
    set_port(2, 1'b1, 1'b0, 8'h22, 32'h2222);
    #1;
    checks++; if (t_ready !== 4'b0100) begin errors++; $display("FAIL rmid_ready: got %b want 0100", t_ready); end
    @(posedge clk); #1;
    checks++; if ({t_stb, t_busy, t_src} !== {1'b1, 1'b1, 2'd2}) begin errors++; $display("FAIL rmid_pre: got stb=%b busy=%b src=%0d want 1/1/2", t_stb, t_busy, t_src); end
    reset_n = 1'b0;
    #1;
    checks++; if (t_stb !== 1'b0) begin errors++; $display("FAIL rmid_stb: got %b want 0", t_stb); end
    checks++; if (t_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", t_busy); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    set_port(0, 1'b1, 1'b1, 8'h01, 32'h0101);
    #1;
    checks++; if (t_ready !== 4'b0001) begin errors++; $display("FAIL rmid_rearb_ready: got %b want 0001", t_ready); end
    @(posedge clk); #1;
    checks++; if ({t_stb, t_src, t_addr} !== {1'b1, 2'd0, 8'h01}) begin errors++; $display("FAIL rmid_rearb: got stb=%b src=%0d addr=%h want 1/0/01", t_stb, t_src, t_addr); end
    tvalid = '0;
  endtask

  task automatic test_drop();
    sel = 2'd0;
    do_reset();
    set_port(1, 1'b1, 1'b0, 8'h31, 32'hA1);
    #1;
    checks++; if (t_ready !== 4'b0010) begin errors++; $display("FAIL drop_first: got %b want 0010", t_ready); end
    @(posedge clk); #1;
    checks++; if ({t_stb, t_src, t_busy} !== {1'b1, 2'd1, 1'b1}) begin errors++; $display("FAIL drop_beat1: got stb=%b src=%0d busy=%b want 1/1/1", t_stb, t_src, t_busy); end
    set_port(1, 1'b0, 1'b0, 8'h00, 32'h0);
    set_port(3, 1'b1, 1'b1, 8'h33, 32'h33);
    #1;
    checks++; if (t_ready !== 4'b0000) begin errors++; $display("FAIL drop_p3_ready: got %b want 0000", t_ready); end
    @(posedge clk); #1;
    checks++; if ({t_stb, t_busy} !== 2'b01) begin errors++; $display("FAIL drop_bubble: got stb=%b busy=%b want 0/1", t_stb, t_busy); end
    set_port(3, 1'b0, 1'b0, 8'h00, 32'h0);
    set_port(1, 1'b1, 1'b1, 8'h32, 32'hA2);
    #1;
    checks++; if (t_ready !== 4'b0010) begin errors++; $display("FAIL drop_beat2_ready: got %b want 0010", t_ready); end
    @(posedge clk); #1;
    checks++; if ({t_stb, t_src, t_addr} !== {1'b1, 2'd1, 8'h32}) begin errors++; $display("FAIL drop_beat2: got stb=%b src=%0d addr=%h want 1/1/32", t_stb, t_src, t_addr); end
    set_port(1, 1'b0, 1'b0, 8'h00, 32'h0);
    @(posedge clk); #1;
    checks++; if ({t_stb, t_busy, t_ready} !== 6'b0) begin errors++; $display("FAIL drop_tail: got stb=%b busy=%b ready=%b want 0/0/0000", t_stb, t_busy, t_ready); end
  endtask

  // Reference model: round-robin pointer, held-port lock, and remaining gap cycles.
  task automatic test_random(input logic [1:0] s, input int gap, input int ncyc);
    int m_last, m_lock, m_gap, g, p;
    logic [N-1:0]  e_rdy;
    logic          e_stb, e_busy, blast;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_data;
    logic [1:0]    e_src;
    logic [BW-1:0] beat;
    sel = s;
    do_reset();
    m_last = N - 1; m_lock = -1; m_gap = 0;
    e_addr = '0; e_data = '0; e_src = '0;
    beat = '0; blast = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      for (int k = 0; k < N; k++)
        set_port(k, ($urandom_range(0, 99) < 55), ($urandom_range(0, 2) == 0), 8'($urandom), $urandom);
      #1;
      g = -1;
      if (m_gap == 0) begin
        if (m_lock >= 0) begin
          if (tvalid[m_lock]) g = m_lock;
        end else begin
          for (int i = 1; i <= N; i++) begin
            p = (m_last + i) % N;
            if (g < 0 && tvalid[p]) g = p;
          end
        end
      end
      e_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      checks++;
      if (t_ready !== e_rdy) begin
        errors++; $display("FAIL rand_ready[gap=%0d c=%0d]: got %b want %b", gap, c, t_ready, e_rdy);
      end
      if (g >= 0) begin
        beat  = tdata[g*BW +: BW];
        blast = tlast[g];
      end
      @(posedge clk); #1;
      if (g >= 0) begin
        e_stb  = 1'b1;
        e_addr = beat[BW-1:32];
        e_data = beat[31:0];
        e_src  = 2'(g);
        m_last = g;
        m_lock = blast ? -1 : g;
        m_gap  = gap;
      end else begin
        e_stb = 1'b0;
        if (m_gap > 0) m_gap--;
      end
      e_busy = (m_lock >= 0) || (m_gap > 0);
      checks++;
      if ({t_stb, t_addr, t_data, t_src, t_busy} !== {e_stb, e_addr, e_data, e_src, e_busy}) begin
        errors++;
        $display("FAIL rand_bus[gap=%0d c=%0d]: got stb=%b addr=%h data=%h src=%0d busy=%b want %b/%h/%h/%0d/%b",
                 gap, c, t_stb, t_addr, t_data, t_src, t_busy, e_stb, e_addr, e_data, e_src, e_busy);
      end
    end
    tvalid = '0;
  endtask

  initial begin
    reset_n = 1'b0;
    sel     = 2'd0;
    tvalid  = '0;
    tlast   = '0;
    tdata   = '0;
    test_reset();
    test_single_beat();
    test_rotation();
    test_lock();
    test_gap();
    test_reset_mid();
    test_drop();
    test_random(2'd0, 0, 400);
    test_random(2'd1, 3, 400);
    test_random(2'd2, 2, 400);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/settings_bus_arbiter.md
# settings_bus_arbiter

Round-robin arbiter that lets several AXI-stream command sources share one settings bus (set_stb/set_addr/set_data). It feeds settings registers and their AXI-stream output variants. Each accepted beat becomes exactly one registered settings-bus strobe. Multi-beat sequences marked by tlast are kept atomic, and a programmable idle gap can be inserted after every strobe for slow downstream consumers.

## Interface
- NUM_PORTS, 4: number of requesters; 2..16.
- AWIDTH, 8: settings address width.
- GAP, 0: idle cycles forced after each strobe; 0..255.
- clk  in  1  clock.
- reset_n  in  1  reset; asynchronous assertion, active-low. All state clears while low.
- i_tdata  in  NUM_PORTS*(AWIDTH+32)  per-port beat. Port k occupies bits [k*(AWIDTH+32) +: AWIDTH+32]. Within that slice, [31:0] is the data and [AWIDTH+31:32] is the address.
- i_tlast  in  NUM_PORTS  per-port end-of-sequence flag.
- i_tvalid  in  NUM_PORTS  per-port valid.
- i_tready  out  NUM_PORTS  per-port ready; at most one bit high in any cycle.
- set_stb  out  1  settings write strobe, one cycle per accepted beat.
- set_addr  out  AWIDTH  settings address; holds its last value between strobes.
- set_data  out  32  settings data; holds its last value between strobes.
- set_src  out  clog2(NUM_PORTS), minimum 1  index of the port whose beat is on the bus; valid with set_stb.
- busy  out  1  high while a sequence is locked or a gap is running.

## Operation
- States:
  - ARB: no lock held.
  - LOCK: holding one port until it delivers tlast.
  - GAP: counting idle cycles.
- ARB:
  - Search from port (last+1) mod NUM_PORTS upward with wrap. The first port with tvalid is the grant g.
  - i_tready[g]=1 combinationally in the same cycle; the handshake completes.
  - `last` is a registered pointer that updates to g on every accepted beat.
- On an accepted beat:
  - The next cycle has set_stb=1, set_addr/set_data taken from port g's slice, and set_src=g.
  - If tlast=0, the block locks to g.
- LOCK: only port g may get i_tready; all other ports stall. Lock releases on the beat from g with tlast=1.
- GAP:
  - Entered after every accepted beat when GAP>0. A count register of 8 bits loads GAP and decrements to 0.
  - No i_tready is asserted during GAP.
  - On exit, go to LOCK if a lock is held, else ARB.
- GAP=0: the GAP state is never entered. Beats may be accepted every cycle.
- Reset values:
  - set_stb=0, set_addr=0, set_data=0, set_src=0, busy=0.
  - last=NUM_PORTS-1, so port 0 wins first; state ARB; lock cleared; gap count 0.
- Input rules: i_tvalid may drop without a handshake. The arbiter re-evaluates every cycle in ARB and never holds a grant without a lock.
- Reset mid-sequence or mid-gap: the lock is abandoned and the next strobe comes from fresh arbitration. set_stb deasserts immediately on reset assertion.

## Timing
- Latency: handshake in cycle N gives set_stb in cycle N+1. The strobe is exactly one cycle wide.
- Throughput: one beat per (1+GAP) cycles, both for a single port and aggregated across ports.
- i_tready is combinational from i_tvalid and the state. No i_tvalid-to-set_* combinational path exists.
- busy is registered. It is high in every cycle where the state is LOCK or GAP.
- Simultaneous events:
  - When the lock-releasing tlast beat is accepted in cycle N, a different port can be granted at cycle N+1 (GAP=0) or at the first cycle after the gap.
  - When all ports are valid with tlast=1 and GAP=0, grants rotate 0,1,2,3,0… on consecutive cycles.

## Test plan
- Reset release with GAP=0, port 2 sends addr 0x15 data 0xDEADBEEF, tlast=1 → i_tready[2] in the same cycle; the next cycle shows set_stb=1, set_addr=0x15, set_data=0xDEADBEEF, set_src=2. All outputs read 0 before the first beat.
- All 4 ports continuously valid with tlast=1 and GAP=0 → set_src sequence 0,1,2,3,0,1 on 6 consecutive strobe cycles, with no idle cycle.
- Port 1 sends a 3-beat sequence (tlast on the 3rd beat) while ports 0 and 3 are valid → three consecutive strobes with set_src=1, then 3, then 0. i_tready[0] and i_tready[3] stay low until the tlast beat.
- GAP=3, port 0 valid continuously → strobes 4 cycles apart; busy is high for the 3 gap cycles and i_tready is all-zero during them.
- Port 2 is in the middle of a sequence with GAP=2 and reset_n is pulsed low for 1 cycle → set_stb=0 and busy=0 immediately. After release, with ports 0 and 2 valid, the first strobe is from port 0.
- Port 3 asserts tvalid for 1 cycle while port 1 holds a lock, then drops it → no strobe from port 3 and no i_tready[3]. Port 1's sequence completes uninterrupted.
